// File: rtl/unified_cache_crossbar_pkg.sv
// rtl/unified_cache_crossbar_pkg.sv - shared packet field positions and helpers
//
// Purpose: packet layout defaults used by the crossbar and its arbiter.
// Ports: none (package).
package unified_cache_crossbar_pkg;

  // Default packet layout: [31] valid, [25:24] port ID, [5:4] bank select.
  localparam int UC_PACKET_WIDTH   = 32;
  localparam int UC_VALID_POS      = 31;
  localparam int UC_PORT_ID_LO     = 24;
  localparam int UC_PORT_ID_WIDTH  = 2;
  localparam int UC_BANK_SEL_LO    = 4;

  // Width of an index into n items; never zero so it can size a vector.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unified_cache_crossbar_rr_arbiter.sv
// rtl/unified_cache_crossbar_rr_arbiter.sv - critical-first round-robin arbiter
//
// Purpose: one-hot grant among NUM_REQUEST requesters for one destination slot.
// Ports:
//   clk_in, reset_in   clock, asynchronous active-low reset
//   request_in         requester valid vector
//   critical_in        per-requester critical flag
//   slot_free_in       destination can take a packet this cycle
//   grant_out          one-hot grant (all zero when slot is not free)
module crossbar_rr_arbiter
  import unified_cache_crossbar_pkg::*;
#(
  parameter int NUM_REQUEST = 2
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [NUM_REQUEST-1:0] request_in,
  input  logic [NUM_REQUEST-1:0] critical_in,
  input  logic                   slot_free_in,
  output logic [NUM_REQUEST-1:0] grant_out
);

  localparam int PW = sel_width(NUM_REQUEST);

  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          ptr_d;
  logic [NUM_REQUEST-1:0] eligible;
  logic                   found;

  always_comb begin
    // Critical requesters, when present, hide all non-critical ones.
    eligible  = ((request_in & critical_in) != '0) ? (request_in & critical_in) : request_in;
    grant_out = '0;
    ptr_d     = ptr_q;
    found     = 1'b0;
    // Scan starting one past the last winner, wrapping modulo NUM_REQUEST.
    for (int k = 1; k <= NUM_REQUEST; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQUEST) idx = idx - NUM_REQUEST;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        if (slot_free_in) begin
          grant_out[idx] = 1'b1;
          ptr_d          = PW'(idx);
        end
      end
    end
  end

  // Pointer resets to the last index so requester 0 is first after reset.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) ptr_q <= PW'(NUM_REQUEST - 1);
    else           ptr_q <= ptr_d;
  end

endmodule

// File: rtl/unified_cache_crossbar.sv
// rtl/unified_cache_crossbar.sv - request/return crossbar between ports and cache banks
//
// Purpose: routes port requests to banks by address bank bits and bank returns
// to ports by port-ID, each destination with a critical-first round-robin
// arbiter and a one-entry registered slot.
// Ports:
//   clk_in, reset_in                      clock, asynchronous active-low reset
//   port_request_*_in / ack_out           requester side of the request path
//   bank_request_*_out / ack_in           bank slots of the request path
//   bank_return_*_in / ack_out            bank side of the return path
//   port_return_*_out / ack_in            port slots of the return path
//   misroute_error_out                    pulse when a return with bad port ID is dropped
module unified_cache_crossbar
  import unified_cache_crossbar_pkg::*;
#(
  parameter int NUM_INPUT_PORT = 2,
  parameter int NUM_BANK       = 4,
  parameter int PACKET_WIDTH   = UC_PACKET_WIDTH,
  parameter int VALID_POS      = UC_VALID_POS,
  parameter int PORT_ID_LO     = UC_PORT_ID_LO,
  parameter int PORT_ID_WIDTH  = UC_PORT_ID_WIDTH,
  parameter int BANK_SEL_LO    = UC_BANK_SEL_LO
) (
  input  logic                               clk_in,
  input  logic                               reset_in,
  input  logic [NUM_INPUT_PORT*PACKET_WIDTH-1:0] port_request_flatted_in,
  input  logic [NUM_INPUT_PORT-1:0]          port_request_critical_flatted_in,
  output logic [NUM_INPUT_PORT-1:0]          port_request_ack_flatted_out,
  output logic [NUM_BANK*PACKET_WIDTH-1:0]   bank_request_flatted_out,
  output logic [NUM_BANK-1:0]                bank_request_valid_flatted_out,
  input  logic [NUM_BANK-1:0]                bank_request_ack_flatted_in,
  input  logic [NUM_BANK*PACKET_WIDTH-1:0]   bank_return_flatted_in,
  input  logic [NUM_BANK-1:0]                bank_return_critical_flatted_in,
  output logic [NUM_BANK-1:0]                bank_return_ack_flatted_out,
  output logic [NUM_INPUT_PORT*PACKET_WIDTH-1:0] port_return_flatted_out,
  output logic [NUM_INPUT_PORT-1:0]          port_return_valid_flatted_out,
  input  logic [NUM_INPUT_PORT-1:0]          port_return_ack_flatted_in,
  output logic                               misroute_error_out
);

  localparam int P   = NUM_INPUT_PORT;
  localparam int B   = NUM_BANK;
  localparam int W   = PACKET_WIDTH;
  localparam int BSW = sel_width(NUM_BANK);

  // ---------------- packet field decode ----------------
  logic [P-1:0]             req_valid;
  logic [BSW-1:0]           req_bank [P];
  logic [B-1:0]             ret_valid;
  logic [B-1:0]             ret_in_range;
  logic [PORT_ID_WIDTH-1:0] ret_pid [B];

  for (genvar gp = 0; gp < P; gp++) begin : g_req_decode
    assign req_valid[gp] = port_request_flatted_in[gp*W + VALID_POS];
    if (B > 1) begin : g_sel
      assign req_bank[gp] = port_request_flatted_in[gp*W + BANK_SEL_LO +: BSW];
    end else begin : g_nosel
      assign req_bank[gp] = '0;
    end
  end

  for (genvar gb = 0; gb < B; gb++) begin : g_ret_decode
    assign ret_valid[gb]    = bank_return_flatted_in[gb*W + VALID_POS];
    assign ret_pid[gb]      = bank_return_flatted_in[gb*W + PORT_ID_LO +: PORT_ID_WIDTH];
    assign ret_in_range[gb] = (int'(ret_pid[gb]) < P);
  end

  // ---------------- request path: ports -> banks ----------------
  logic [P-1:0]   bank_req [B];
  logic [P-1:0]   bank_gnt [B];
  logic [B-1:0]   bank_valid_q, bank_valid_d;
  logic [B*W-1:0] bank_data_q, bank_data_d;
  logic [B-1:0]   bank_slot_free;
  logic [P-1:0]   port_req_ack;

  // A slot is free when empty or being drained this cycle (no bubble).
  assign bank_slot_free = ~bank_valid_q | bank_request_ack_flatted_in;

  always_comb begin
    for (int b = 0; b < B; b++) begin
      for (int p = 0; p < P; p++) begin
        bank_req[b][p] = req_valid[p] && (int'(req_bank[p]) == b);
      end
    end
  end

  for (genvar gb = 0; gb < B; gb++) begin : g_bank_arb
    crossbar_rr_arbiter #(.NUM_REQUEST(P)) u_arb (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .request_in   (bank_req[gb]),
      .critical_in  (port_request_critical_flatted_in),
      .slot_free_in (bank_slot_free[gb]),
      .grant_out    (bank_gnt[gb])
    );
  end

  always_comb begin
    port_req_ack = '0;
    bank_valid_d = bank_valid_q;
    bank_data_d  = bank_data_q;
    for (int b = 0; b < B; b++) begin
      if (bank_gnt[b] != '0) begin
        bank_valid_d[b] = 1'b1;
        bank_data_d[b*W +: W] = '0;
        for (int p = 0; p < P; p++) begin
          if (bank_gnt[b][p]) begin
            bank_data_d[b*W +: W] = bank_data_d[b*W +: W] | port_request_flatted_in[p*W +: W];
            port_req_ack[p]       = 1'b1;
          end
        end
      end else if (bank_request_ack_flatted_in[b]) begin
        bank_valid_d[b] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      bank_valid_q <= '0;
      bank_data_q  <= '0;
    end else begin
      bank_valid_q <= bank_valid_d;
      bank_data_q  <= bank_data_d;
    end
  end

  // ---------------- return path: banks -> ports ----------------
  logic [B-1:0]   port_req [P];
  logic [B-1:0]   port_gnt [P];
  logic [P-1:0]   port_valid_q, port_valid_d;
  logic [P*W-1:0] port_data_q, port_data_d;
  logic [P-1:0]   port_slot_free;
  logic [B-1:0]   ret_drop;
  logic [B-1:0]   bank_ret_ack;

  assign port_slot_free = ~port_valid_q | port_return_ack_flatted_in;
  // Returns naming a non-existent port are accepted and discarded at once.
  assign ret_drop       = ret_valid & ~ret_in_range;

  always_comb begin
    for (int p = 0; p < P; p++) begin
      for (int b = 0; b < B; b++) begin
        port_req[p][b] = ret_valid[b] && ret_in_range[b] && (int'(ret_pid[b]) == p);
      end
    end
  end

  for (genvar gp = 0; gp < P; gp++) begin : g_port_arb
    crossbar_rr_arbiter #(.NUM_REQUEST(B)) u_arb (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .request_in   (port_req[gp]),
      .critical_in  (bank_return_critical_flatted_in),
      .slot_free_in (port_slot_free[gp]),
      .grant_out    (port_gnt[gp])
    );
  end

  always_comb begin
    bank_ret_ack = ret_drop;
    port_valid_d = port_valid_q;
    port_data_d  = port_data_q;
    for (int p = 0; p < P; p++) begin
      if (port_gnt[p] != '0) begin
        port_valid_d[p] = 1'b1;
        port_data_d[p*W +: W] = '0;
        for (int b = 0; b < B; b++) begin
          if (port_gnt[p][b]) begin
            port_data_d[p*W +: W] = port_data_d[p*W +: W] | bank_return_flatted_in[b*W +: W];
            bank_ret_ack[b]       = 1'b1;
          end
        end
      end else if (port_return_ack_flatted_in[p]) begin
        port_valid_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      port_valid_q <= '0;
      port_data_q  <= '0;
    end else begin
      port_valid_q <= port_valid_d;
      port_data_q  <= port_data_d;
    end
  end

  // ---------------- outputs ----------------
  assign port_request_ack_flatted_out   = port_req_ack;
  assign bank_request_flatted_out       = bank_data_q;
  assign bank_request_valid_flatted_out = bank_valid_q;
  assign bank_return_ack_flatted_out    = bank_ret_ack;
  assign port_return_flatted_out        = port_data_q;
  assign port_return_valid_flatted_out  = port_valid_q;
  // Held low while in reset so the pulse never appears outside normal operation.
  assign misroute_error_out             = reset_in & (|ret_drop);

endmodule

// File: tb/tb_unified_cache_crossbar.sv
// tb/tb_unified_cache_crossbar.sv - self-checking bench for unified_cache_crossbar
module tb_unified_cache_crossbar;

  localparam int P = 2;
  localparam int B = 4;
  localparam int W = 32;

  logic           clk_in = 1'b0;
  logic           reset_in;
  logic [P*W-1:0] port_req;
  logic [P-1:0]   port_crit;
  logic [P-1:0]   port_req_ack;
  logic [B*W-1:0] bank_req;
  logic [B-1:0]   bank_req_valid;
  logic [B-1:0]   bank_req_ack;
  logic [B*W-1:0] bank_ret;
  logic [B-1:0]   bank_ret_crit;
  logic [B-1:0]   bank_ret_ack;
  logic [P*W-1:0] port_ret;
  logic [P-1:0]   port_ret_valid;
  logic [P-1:0]   port_ret_ack;
  logic           misroute;

  unified_cache_crossbar #(
    .NUM_INPUT_PORT(P), .NUM_BANK(B), .PACKET_WIDTH(W), .VALID_POS(31),
    .PORT_ID_LO(24), .PORT_ID_WIDTH(2), .BANK_SEL_LO(4)
  ) dut (
    .clk_in                           (clk_in),
    .reset_in                         (reset_in),
    .port_request_flatted_in          (port_req),
    .port_request_critical_flatted_in (port_crit),
    .port_request_ack_flatted_out     (port_req_ack),
    .bank_request_flatted_out         (bank_req),
    .bank_request_valid_flatted_out   (bank_req_valid),
    .bank_request_ack_flatted_in      (bank_req_ack),
    .bank_return_flatted_in           (bank_ret),
    .bank_return_critical_flatted_in  (bank_ret_crit),
    .bank_return_ack_flatted_out      (bank_ret_ack),
    .port_return_flatted_out          (port_ret),
    .port_return_valid_flatted_out    (port_ret_valid),
    .port_return_ack_flatted_in       (port_ret_ack),
    .misroute_error_out               (misroute)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] rq(input int bank, input int tag);
    return 32'h8000_0000 | (32'(tag & 255) << 8) | (32'(bank & 3) << 4);
  endfunction

  function automatic logic [31:0] rt(input int pid, input int tag);
    return 32'h8000_0000 | (32'(pid & 3) << 24) | 32'(tag & 255);
  endfunction

  // Reference arbitration: critical class first, then first requester after 'last'.
  function automatic int arb(input logic [15:0] req, input logic [15:0] crit, input int n, input int last);
    logic [15:0] pool;
    pool = ((req & crit) != 16'h0) ? (req & crit) : req;
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (last + k) % n;
      if (pool[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    port_req = '0; port_crit = '0; bank_req_ack = '1;
    bank_ret = '0; bank_ret_crit = '0; port_ret_ack = '1;
  endtask

  typedef struct {
    logic [31:0] p0;
    logic [31:0] p1;
    logic [1:0]  crit;
    logic [1:0]  exp_ack;
    logic [3:0]  exp_valid;
    int          chk_bank;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [7];

  // Random-phase model state
  logic        mb_valid [B];
  logic [31:0] mb_data  [B];
  int          mb_last  [B];
  logic        mp_valid [P];
  logic [31:0] mp_data  [P];
  int          mp_last  [P];
  logic        sp_pend [P];
  logic [31:0] sp_pkt  [P];
  logic        sp_crit [P];
  logic        sb_pend [B];
  logic [31:0] sb_pkt  [B];
  logic        sb_crit [B];

  initial begin
    vt[0] = '{32'h8000_00A5, 32'h0,    2'b00, 2'b01, 4'b0100, 2, 32'h8000_00A5};
    vt[1] = '{rq(1, 1),      rq(1, 2), 2'b00, 2'b01, 4'b0010, 1, rq(1, 1)};
    vt[2] = '{rq(1, 3),      rq(1, 2), 2'b00, 2'b10, 4'b0010, 1, rq(1, 2)};
    vt[3] = '{rq(0, 4),      rq(0, 5), 2'b10, 2'b10, 4'b0001, 0, rq(0, 5)};
    vt[4] = '{rq(0, 4),      32'h0,    2'b00, 2'b01, 4'b0001, 0, rq(0, 4)};
    vt[5] = '{rq(3, 6),      rq(2, 7), 2'b00, 2'b11, 4'b1100, 3, rq(3, 6)};
    vt[6] = '{32'h0,         32'h0,    2'b00, 2'b00, 4'b0000, 3, rq(3, 6)};

    idle();
    reset_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_bank_valid", 128'(bank_req_valid), 128'h0);
    check("reset_bank_data", 128'(bank_req), 128'h0);
    check("reset_port_valid", 128'(port_ret_valid), 128'h0);
    check("reset_misroute", 128'(misroute), 128'h0);
    reset_in = 1'b1;

    // Table-driven request path
    for (int r = 0; r < 7; r++) begin
      port_req = {vt[r].p1, vt[r].p0};
      port_crit = vt[r].crit;
      bank_req_ack = '1;
      #3;
      check($sformatf("vec%0d_ack", r), 128'(port_req_ack), 128'(vt[r].exp_ack));
      step();
      check($sformatf("vec%0d_valid", r), 128'(bank_req_valid), 128'(vt[r].exp_valid));
      check($sformatf("vec%0d_data", r), 128'(bank_req[vt[r].chk_bank*W +: W]), 128'(vt[r].exp_data));
    end

    // Fairness: both ports stream into bank1, grants alternate without bubbles
    for (int k = 0; k < 4; k++) begin
      port_req = {rq(1, 8'h20), rq(1, 8'h10)};
      port_crit = '0;
      #3;
      check($sformatf("rr%0d_ack", k), 128'(port_req_ack), (k % 2 == 0) ? 128'h1 : 128'h2);
      step();
      check($sformatf("rr%0d_valid", k), 128'(bank_req_valid), 128'h2);
      check($sformatf("rr%0d_data", k), 128'(bank_req[1*W +: W]),
            (k % 2 == 0) ? 128'(rq(1, 8'h10)) : 128'(rq(1, 8'h20)));
    end
    idle();
    step();

    // Backpressure on bank3
    bank_req_ack = '0;
    port_req = {32'h0, rq(3, 8'h31)};
    #3;
    check("bp_fill_ack", 128'(port_req_ack), 128'h1);
    step();
    check("bp_fill_data", 128'(bank_req[3*W +: W]), 128'(rq(3, 8'h31)));
    port_req = {rq(3, 8'h32), 32'h0};
    for (int k = 0; k < 4; k++) begin
      #3;
      check($sformatf("bp_hold%0d_ack", k), 128'(port_req_ack), 128'h0);
      step();
      check($sformatf("bp_hold%0d_valid", k), 128'(bank_req_valid), 128'h8);
      check($sformatf("bp_hold%0d_data", k), 128'(bank_req[3*W +: W]), 128'(rq(3, 8'h31)));
    end
    bank_req_ack = 4'b1000;
    #3;
    check("bp_release_ack", 128'(port_req_ack), 128'h2);
    step();
    check("bp_refill_valid", 128'(bank_req_valid), 128'h8);
    check("bp_refill_data", 128'(bank_req[3*W +: W]), 128'(rq(3, 8'h32)));
    idle();
    step();
    check("bp_drained", 128'(bank_req_valid), 128'h0);

    // Return routing: bank0 and bank2 both to port1
    bank_ret[0*W +: W] = rt(1, 8'hB0);
    bank_ret[2*W +: W] = rt(1, 8'hB2);
    #3;
    check("ret0_ack", 128'(bank_ret_ack), 128'h1);
    step();
    check("ret0_valid", 128'(port_ret_valid), 128'h2);
    check("ret0_data", 128'(port_ret[1*W +: W]), 128'(rt(1, 8'hB0)));
    bank_ret[0*W +: W] = '0;
    #3;
    check("ret1_ack", 128'(bank_ret_ack), 128'h4);
    step();
    check("ret1_data", 128'(port_ret[1*W +: W]), 128'(rt(1, 8'hB2)));
    bank_ret[2*W +: W] = '0;
    step();
    check("ret_drained", 128'(port_ret_valid), 128'h0);

    // Misroute: port ID 3 with two ports
    bank_ret[1*W +: W] = rt(3, 8'hC1);
    #3;
    check("mis_ack", 128'(bank_ret_ack), 128'h2);
    check("mis_pulse", 128'(misroute), 128'h1);
    step();
    bank_ret[1*W +: W] = '0;
    #3;
    check("mis_clear", 128'(misroute), 128'h0);
    check("mis_no_write_valid", 128'(port_ret_valid), 128'h0);
    check("mis_no_write_data", 128'(port_ret), 128'({rt(1, 8'hB2), 32'h0}));
    step();

    // Asynchronous reset mid-transfer
    bank_req_ack = '0;
    port_ret_ack = '0;
    port_req = {32'h0, rq(2, 8'h55)};
    bank_ret[0*W +: W] = rt(0, 8'h66);
    step();
    check("pre_reset_bank_valid", 128'(bank_req_valid), 128'h4);
    check("pre_reset_port_valid", 128'(port_ret_valid), 128'h1);
    reset_in = 1'b0;
    #1;
    check("async_reset_bank_valid", 128'(bank_req_valid), 128'h0);
    check("async_reset_port_valid", 128'(port_ret_valid), 128'h0);
    check("async_reset_data", 128'(bank_req), 128'h0);
    idle();
    step();
    reset_in = 1'b1;

    // Randomized run against the reference model
    for (int i = 0; i < B; i++) begin
      mb_valid[i] = 1'b0; mb_data[i] = '0; mb_last[i] = P - 1; sb_pend[i] = 1'b0;
      sb_pkt[i] = '0; sb_crit[i] = 1'b0;
    end
    for (int i = 0; i < P; i++) begin
      mp_valid[i] = 1'b0; mp_data[i] = '0; mp_last[i] = B - 1; sp_pend[i] = 1'b0;
      sp_pkt[i] = '0; sp_crit[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int gb [B];
      int gp [P];
      logic [P-1:0]   e_pack;
      logic [B-1:0]   e_back;
      logic           e_mis;
      logic [B*W-1:0] e_bdata;
      logic [P*W-1:0] e_pdata;
      logic [B-1:0]   e_bvalid;
      logic [P-1:0]   e_pvalid;

      for (int p = 0; p < P; p++) begin
        if (!sp_pend[p] && $urandom_range(0, 2) != 0) begin
          sp_pend[p] = 1'b1;
          sp_pkt[p]  = rq($urandom_range(0, 3), $urandom_range(0, 255));
          sp_crit[p] = ($urandom_range(0, 3) == 0);
        end
        port_req[p*W +: W] = sp_pend[p] ? sp_pkt[p] : ($urandom() & 32'h7fff_ffff);
        port_crit[p]       = sp_pend[p] ? sp_crit[p] : 1'($urandom_range(0, 1));
        port_ret_ack[p]    = ($urandom_range(0, 3) != 0);
      end
      for (int b = 0; b < B; b++) begin
        if (!sb_pend[b] && $urandom_range(0, 1) != 0) begin
          sb_pend[b] = 1'b1;
          sb_pkt[b]  = rt(($urandom_range(0, 5) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1),
                          $urandom_range(0, 255));
          sb_crit[b] = ($urandom_range(0, 3) == 0);
        end
        bank_ret[b*W +: W] = sb_pend[b] ? sb_pkt[b] : ($urandom() & 32'h7fff_ffff);
        bank_ret_crit[b]   = sb_pend[b] ? sb_crit[b] : 1'($urandom_range(0, 1));
        bank_req_ack[b]    = ($urandom_range(0, 3) != 0);
      end
      #3;

      e_pack = '0;
      for (int b = 0; b < B; b++) begin
        logic [15:0] rv, cv;
        int w;
        rv = '0; cv = '0;
        for (int p = 0; p < P; p++) begin
          rv[p] = sp_pend[p] && (int'(sp_pkt[p][5:4]) == b);
          cv[p] = sp_crit[p];
        end
        w = arb(rv, cv, P, mb_last[b]);
        gb[b] = (w >= 0 && (!mb_valid[b] || bank_req_ack[b])) ? w : -1;
        if (gb[b] >= 0) e_pack[gb[b]] = 1'b1;
      end
      e_back = '0;
      e_mis  = 1'b0;
      for (int b = 0; b < B; b++) begin
        if (sb_pend[b] && int'(sb_pkt[b][25:24]) >= P) begin
          e_back[b] = 1'b1;
          e_mis     = 1'b1;
        end
      end
      for (int p = 0; p < P; p++) begin
        logic [15:0] rv, cv;
        int w;
        rv = '0; cv = '0;
        for (int b = 0; b < B; b++) begin
          rv[b] = sb_pend[b] && (int'(sb_pkt[b][25:24]) == p);
          cv[b] = sb_crit[b];
        end
        w = arb(rv, cv, B, mp_last[p]);
        gp[p] = (w >= 0 && (!mp_valid[p] || port_ret_ack[p])) ? w : -1;
        if (gp[p] >= 0) e_back[gp[p]] = 1'b1;
      end
      for (int b = 0; b < B; b++) begin
        e_bvalid[b] = mb_valid[b];
        e_bdata[b*W +: W] = mb_data[b];
      end
      for (int p = 0; p < P; p++) begin
        e_pvalid[p] = mp_valid[p];
        e_pdata[p*W +: W] = mp_data[p];
      end

      check($sformatf("rnd%0d_port_ack", cyc), 128'(port_req_ack), 128'(e_pack));
      check($sformatf("rnd%0d_bank_ret_ack", cyc), 128'(bank_ret_ack), 128'(e_back));
      check($sformatf("rnd%0d_misroute", cyc), 128'(misroute), 128'(e_mis));
      check($sformatf("rnd%0d_bank_valid", cyc), 128'(bank_req_valid), 128'(e_bvalid));
      check($sformatf("rnd%0d_bank_data", cyc), 128'(bank_req), 128'(e_bdata));
      check($sformatf("rnd%0d_port_valid", cyc), 128'(port_ret_valid), 128'(e_pvalid));
      check($sformatf("rnd%0d_port_data", cyc), 128'(port_ret), 128'(e_pdata));

      for (int b = 0; b < B; b++) begin
        if (gb[b] >= 0) begin
          mb_valid[b] = 1'b1;
          mb_data[b]  = sp_pkt[gb[b]];
          mb_last[b]  = gb[b];
          sp_pend[gb[b]] = 1'b0;
        end else if (bank_req_ack[b]) begin
          mb_valid[b] = 1'b0;
        end
      end
      for (int p = 0; p < P; p++) begin
        if (gp[p] >= 0) begin
          mp_valid[p] = 1'b1;
          mp_data[p]  = sb_pkt[gp[p]];
          mp_last[p]  = gp[p];
          sb_pend[gp[p]] = 1'b0;
        end else if (port_ret_ack[p]) begin
          mp_valid[p] = 1'b0;
        end
      end
      for (int b = 0; b < B; b++) begin
        if (sb_pend[b] && int'(sb_pkt[b][25:24]) >= P) sb_pend[b] = 1'b0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
